rv_ifetch: RTL and testbench

Instruction-fetch aligner between the `rv_core` instruction port and a 32-bit word-organised synchronous instruction memory. Converts halfword-aligned RV32EC fetch addresses into word reads, and stitches 32-bit instructions that straddle a word boundary. A one-word line buffer makes sequential misaligned fetches single-cycle. Misaligned fetches that miss the buffer take one extra memory read and stall `i_rdy`.

---
 rtl/rv_ifetch_pkg.sv | 27 ++
 rtl/rv_ifetch_buf.sv | 41 ++++
 rtl/rv_ifetch.sv | 112 +++++++++++
 tb/tb_rv_ifetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_ifetch_pkg.sv
// Shared types for the RV32EC instruction-fetch aligner.
package rv_ifetch_pkg;

    typedef logic [31:0] u32_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        FILL = 1'b1
    } fetch_st_t;

    typedef enum logic [1:0] {
        ALN   = 2'd0,
        MHIT  = 2'd1,
        MMISS = 2'd2
    } fetch_kind_t;

    typedef struct packed {
        logic [29:0] w;
        logic        h;
    } fetch_req_t;

    // Upper halfword of the instruction comes from the higher word.
    function automatic u32_t stitch(input u32_t hi_word, input u32_t lo_word);
        return {hi_word[15:0], lo_word[31:16]};
    endfunction

endpackage

// File: rtl/rv_ifetch_buf.sv
// One-word line buffer: last memory word read, its word tag and a valid bit.
module rv_ifetch_buf
    import rv_ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        xreset,
    input  logic        wr_en,
    input  logic [29:0] wr_tag,
    input  u32_t        wr_data,
    input  logic        inv,
    input  logic [29:0] lk_tag,
    output u32_t        rd_data,
    output logic        hit
);

    u32_t        line;
    logic [29:0] tag;
    logic        buf_v;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            line  <= '0;
            tag   <= '0;
            buf_v <= 1'b0;
        end else begin
            if (wr_en) begin
                line <= wr_data;
                tag  <= wr_tag;
            end
            // Data is still kept on invalidate; a pending FILL stitch needs it.
            if (inv)
                buf_v <= 1'b0;
            else if (wr_en)
                buf_v <= 1'b1;
        end
    end

    assign rd_data = line;
    assign hit     = buf_v && (tag == lk_tag);

endmodule

// File: rtl/rv_ifetch.sv
// Halfword-aligned fetch to word-memory aligner; stitches straddling 32-bit
// instructions using a one-word line buffer or a second memory read.
module rv_ifetch
    import rv_ifetch_pkg::*;
#(
    parameter bit BUF_EN = 1'b1
) (
    input  logic clk,
    input  logic xreset,
    input  u32_t i_adr,
    input  logic i_re,
    output u32_t i_dr,
    output logic i_rdy,
    input  logic i_inv,
    output u32_t m_adr,
    output logic m_re,
    input  u32_t m_dr,
    input  logic m_rdy
);

    fetch_st_t   st;
    fetch_kind_t kind;
    fetch_req_t  rq;
    logic        pv;
    logic        run_ok;
    u32_t        ma_q;
    u32_t        dr_q;

    logic [29:0] w_in, rq_nxt, iss_w, wr_tag;
    logic        stall, dcyc, miss_dat, issue, hit_in, bhit;
    fetch_kind_t iss_kind;
    u32_t        bdata;
    logic        unused_bit0;

    assign unused_bit0 = i_adr[0];
    assign w_in        = i_adr[31:2];
    assign rq_nxt      = rq.w + 30'd1;

    assign stall    = pv && !m_rdy;
    assign dcyc     = pv && m_rdy;
    assign miss_dat = dcyc && (st == RUN) && (kind == MMISS);
    // FILL always has a read outstanding, so "not stalled" there is its data cycle.
    assign issue    = run_ok && i_re && !stall && !miss_dat;

    assign hit_in   = BUF_EN && i_adr[1] && bhit;
    assign iss_w    = hit_in ? w_in + 30'd1 : w_in;
    assign iss_kind = !i_adr[1] ? ALN : (hit_in ? MHIT : MMISS);

    assign m_re = issue || miss_dat || stall;

    always_comb begin
        m_adr = '0;
        if (run_ok) begin
            if (stall)
                m_adr = ma_q;
            else if (miss_dat)
                m_adr = {rq_nxt, 2'b00};
            else
                m_adr = {iss_w, 2'b00};
        end
    end

    assign i_rdy  = dcyc && !miss_dat;
    assign i_dr   = i_rdy ? (rq.h ? stitch(m_dr, bdata) : m_dr) : dr_q;
    // Aligned reads and the first half of a miss hold word rq_w; the rest hold rq_w+1.
    assign wr_tag = (st == RUN && kind != MHIT) ? rq.w : rq_nxt;

    rv_ifetch_buf u_buf (
        .clk     (clk),
        .xreset  (xreset),
        .wr_en   (dcyc),
        .wr_tag  (wr_tag),
        .wr_data (m_dr),
        .inv     (i_inv),
        .lk_tag  (w_in),
        .rd_data (bdata),
        .hit     (bhit)
    );

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            st     <= RUN;
            kind   <= ALN;
            rq     <= '0;
            pv     <= 1'b0;
            run_ok <= 1'b0;
            ma_q   <= '0;
            dr_q   <= '0;
        end else begin
            run_ok <= 1'b1;
            if (i_rdy)
                dr_q <= i_dr;
            if (m_re)
                ma_q <= m_adr;
            if (!stall) begin
                if (miss_dat) begin
                    st <= FILL;
                    pv <= 1'b1;
                end else begin
                    st <= RUN;
                    pv <= issue;
                    if (issue) begin
                        rq.w <= w_in;
                        rq.h <= i_adr[1];
                        kind <= iss_kind;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_ifetch.sv
// Self-checking bench for rv_ifetch: directed cycle table, reset/FILL sequence
// and randomized single fetches against a halfword-level reference model.
module tb_rv_ifetch;
    import rv_ifetch_pkg::*;

    logic clk = 1'b0;
    logic xreset = 1'b0;
    u32_t i_adr, i_dr, m_adr, m_dr;
    logic i_re, i_rdy, i_inv, m_re, m_rdy;
    u32_t mem_a = '0;
    int   n_run = 0;
    int   n_fail = 0;

    typedef struct {
        logic re;    u32_t adr;    logic mrdy;  logic inv;
        logic e_mre; u32_t e_madr; logic e_rdy; u32_t e_dr;
    } vec_t;
    vec_t tbl[28];

    always #5 clk = ~clk;

    rv_ifetch #(.BUF_EN(1'b1)) dut (
        .clk(clk), .xreset(xreset), .i_adr(i_adr), .i_re(i_re), .i_dr(i_dr),
        .i_rdy(i_rdy), .i_inv(i_inv), .m_adr(m_adr), .m_re(m_re),
        .m_dr(m_dr), .m_rdy(m_rdy)
    );

    function automatic u32_t memw(input logic [29:0] k);
        return 32'hA000_0000 + {2'b00, k};
    endfunction

    always @(posedge clk) if (m_re) mem_a <= m_adr;
    assign m_dr = memw(mem_a[31:2]);

    function automatic logic [15:0] half(input u32_t a);
        u32_t w;
        w = memw(a[31:2]);
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Instruction at a halfword address: two consecutive halfwords, modulo 2^32.
    function automatic u32_t ref_instr(input u32_t a);
        u32_t a0;
        a0 = {a[31:1], 1'b0};
        return {half(a0 + 32'd2), half(a0)};
    endfunction

    task automatic chk(input string name, input u32_t act, input u32_t exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic re, input u32_t adr, input logic rdy, input logic inv);
        i_re = re; i_adr = adr; m_rdy = rdy; i_inv = inv;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        mv, hit, got, inv;
        logic [29:0] mtag, w;
        u32_t        a, last;
        int          base, nstall, lat;

        tbl[0]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};
        tbl[1]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'hA000_0000};
        tbl[2]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'hA000_0001};
        tbl[3]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0002};
        tbl[4]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'hA000_0002};
        tbl[5]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0000};
        tbl[6]  = '{1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'hA000_0000};
        tbl[7]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0001_A000};
        tbl[8]  = '{1'b1, 32'h0000_0102, 1'b1, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0001_A000};
        tbl[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 1'b0, 32'h0001_A000};
        tbl[10] = '{1'b1, 32'h0000_0104, 1'b1, 1'b0, 1'b1, 32'h0000_0104, 1'b1, 32'h0041_A000};
        tbl[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0041};
        tbl[12] = '{1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'hA000_0041};
        tbl[13] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'hA000_0041};
        tbl[14] = '{1'b1, 32'h0000_0050, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'hA000_0041};
        tbl[15] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'hA000_0041};
        tbl[16] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0004};
        tbl[17] = '{1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'hA000_0004};
        tbl[18] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'hA000_0000};
        tbl[19] = '{1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'hA000_0000};
        tbl[20] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'hA000_0000};
        tbl[21] = '{1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0001_A000};
        tbl[22] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 32'h0001_A000};
        tbl[23] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'bx, 32'h0000_0000, 1'b1, 32'h0002_A000};
        tbl[24] = '{1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0002_A000};
        tbl[25] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0002_A000};
        tbl[26] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'bx, 32'h0000_0000, 1'b1, 32'h0000_DFFF};
        tbl[27] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_DFFF};

        // Reset state, with a live request on the inputs.
        drive(1'b1, 32'h0000_0044, 1'b1, 1'b0);
        #1;
        chk("rst_i_dr", i_dr, 32'h0);
        chk("rst_i_rdy", {31'b0, i_rdy}, 32'h0);
        chk("rst_m_adr", m_adr, 32'h0);
        chk("rst_m_re", {31'b0, m_re}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        xreset = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        next_cyc();

        // Directed cycle table.
        for (int r = 0; r < 28; r++) begin
            drive(tbl[r].re, tbl[r].adr, tbl[r].mrdy, tbl[r].inv);
            @(negedge clk);
            if (!$isunknown(tbl[r].e_mre))
                chk($sformatf("row%0d_m_re", r), {31'b0, m_re}, {31'b0, tbl[r].e_mre});
            if (tbl[r].e_mre === 1'b1)
                chk($sformatf("row%0d_m_adr", r), m_adr, tbl[r].e_madr);
            chk($sformatf("row%0d_i_rdy", r), {31'b0, i_rdy}, {31'b0, tbl[r].e_rdy});
            chk($sformatf("row%0d_i_dr", r), i_dr, tbl[r].e_dr);
            next_cyc();
        end

        // Randomized single fetches; buffer model starts invalidated.
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        next_cyc();
        mv = 1'b0; mtag = '0; last = '0;
        for (int t = 0; t < 300; t++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                inv = ($urandom_range(0, 3) == 0);
                drive(1'b0, $urandom, $urandom_range(0, 3) != 0, inv);
                @(negedge clk);
                chk("idle_i_rdy", {31'b0, i_rdy}, 32'h0);
                next_cyc();
                if (inv) mv = 1'b0;
            end
            if ($urandom_range(0, 5) == 0)
                a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 7) * 2);
            else if ($urandom_range(0, 1) == 1)
                a = last + 32'($urandom_range(1, 2) * 2);
            else
                a = 32'($urandom_range(0, 31) * 2);
            a = a | 32'($urandom_range(0, 1));
            last = {a[31:1], 1'b0};
            w = a[31:2];
            hit = a[1] && mv && (mtag == w);
            inv = ($urandom_range(0, 7) == 0);
            drive(1'b1, a, $urandom_range(0, 3) != 0, inv);
            @(negedge clk);
            chk("iss_m_re", {31'b0, m_re}, 32'h1);
            chk("iss_m_adr", m_adr, {(hit ? w + 30'd1 : w), 2'b00});
            next_cyc();
            base = (a[1] && !hit) ? 2 : 1;
            nstall = 0; lat = 0; got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                drive(1'b0, $urandom, $urandom_range(0, 3) != 0, 1'b0);
                @(negedge clk);
                lat++;
                if (!m_rdy) nstall++;
                if (i_rdy) begin
                    got = 1'b1;
                    chk("rsp_i_dr", i_dr, ref_instr(a));
                    chk("rsp_latency", 32'(lat), 32'(base + nstall));
                end
                next_cyc();
            end
            if (!got) chk("rsp_timeout", 32'h0, 32'h1);
            mv = 1'b1;
            mtag = a[1] ? w + 30'd1 : w;
        end

        // Reset while in FILL, then a cold misaligned fetch.
        drive(1'b1, 32'h0000_0202, 1'b1, 1'b0);
        next_cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        next_cyc();
        #1;
        chk("fill_i_rdy", {31'b0, i_rdy}, 32'h1);
        xreset = 1'b0;
        #1;
        chk("rstfill_i_rdy", {31'b0, i_rdy}, 32'h0);
        chk("rstfill_i_dr", i_dr, 32'h0);
        chk("rstfill_m_adr", m_adr, 32'h0);
        chk("rstfill_m_re", {31'b0, m_re}, 32'h0);
        @(negedge clk);
        drive(1'b1, 32'h0000_0002, 1'b1, 1'b0);
        @(negedge clk);
        xreset = 1'b1;
        #1;
        chk("rel_m_re", {31'b0, m_re}, 32'h0);
        chk("rel_i_rdy", {31'b0, i_rdy}, 32'h0);
        next_cyc();
        chk("cold_m_adr0", m_adr, 32'h0);
        chk("cold_m_re0", {31'b0, m_re}, 32'h1);
        next_cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        chk("cold_m_adr1", m_adr, 32'h4);
        chk("cold_i_rdy1", {31'b0, i_rdy}, 32'h0);
        next_cyc();
        chk("cold_i_rdy2", {31'b0, i_rdy}, 32'h1);
        chk("cold_i_dr2", i_dr, 32'h0001_A000);
        next_cyc();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
